aes_round_sequencer: RTL and testbench
======================================

// Module: aes_round_sequencer
// PURPOSE
//  Parametrised AES control FSM for AES-128/192/256 (Nr = 10/12/14), ECB/CBC/CTR, encrypt/decrypt/key-derivation.
//  Key size is selected at run time; COL_PAR columns are processed per beat.
//  Drives column enables, S-box/G-function selects, key-schedule steps, IV xor/counter strobes and the round count
//  to the AES datapath and key-expansion unit.
//  Adds a done/ack handshake and config-error flagging beneath the host interface.
// PARAMETERS
//  COLS     4  state columns per block (Nb)
//  COL_PAR  1  columns processed per beat (1, 2 or 4); BEATS = COLS/COL_PAR
//  RND_W    4  width of the round counter; must hold 14
// PORTS
//  clk             in   1         system clock, all flops rising-edge
//  rst_n           in   1         asynchronous active-low reset
//  start           in   1         launch request; sampled only in IDLE
//  disable_core    in   1         synchronous abort to IDLE
//  operation_mode  in   2         00 ENC, 01 KEY_DERIVATION, 10 DEC, 11 DEC_W_DERIV
//  aes_mode        in   2         00 ECB, 01 CBC, 10 CTR, 11 reserved
//  key_size        in   2         00 128, 01 192, 10 256, 11 reserved
//  done_ack        in   1         host has consumed the result
//  busy            out  1         high in every state except IDLE
//  done            out  1         result valid; held until done_ack
//  round           out  RND_W     current round number, 0..Nr
//  last_round      out  1         round == Nr
//  beat            out  2         column-group index of the current beat
//  col_en          out  COLS      one-hot-group column write enable
//  sbox_g          out  1         S-box input is the key word (G-function)
//  key_step        out  1         advance key schedule by one round
//  key_dir         out  1         0 = forward schedule, 1 = inverse schedule
//  bypass_mix      out  1         skip MixColumns (INIT beats and round Nr)
//  enc_dec         out  1         1 = encrypt datapath (ENC, KEY_DERIVATION, or any CTR)
//  xor_iv_in       out  1         CBC encrypt: xor IV into input during INIT
//  xor_iv_out      out  1         CBC decrypt or CTR: xor IV/input during round Nr
//  iv_cnt_en       out  1         CTR: 1-cycle counter increment
//  cfg_err         out  1         1-cycle pulse on a rejected start
// BEHAVIOUR
//  Reset: all outputs 0, round = 0, state IDLE.
//  Config latch: operation_mode, aes_mode and key_size are latched on an accepted start; later input changes are ignored.
//  CTR mode: op forced to ENC.
//  Rejected start: key_size = 11 or aes_mode = 11 -> start ignored, cfg_err pulses in the next cycle, FSM stays IDLE.
//  States:
//   IDLE:  start -> DERIV for KEY_DERIVATION or DEC_W_DERIV, otherwise INIT.
//   DERIV: Nr x {G cycle: sbox_g=1 ; update cycle: key_step=1, key_dir=0}; round counts 1..Nr.
//          On exit: KEY_DERIVATION -> DONE; DEC_W_DERIV -> INIT with round reset to 0.
//   INIT:  BEATS beats of AddRoundKey only, bypass_mix=1.
//   KEYG:  1 cycle, sbox_g=1, key_step=1, key_dir = ~enc_dec, round++.
//   RND:   BEATS beats.
//   DONE:  done=1 until done_ack.
//  Transitions: INIT -> KEYG; KEYG -> RND; RND -> KEYG, or DONE if last_round; DONE & done_ack -> IDLE.
//  beat: counts 0..BEATS-1 for encrypt, BEATS-1..0 for decrypt; it wraps at a phase boundary.
//  col_en: col_en[beat*COL_PAR +: COL_PAR] = all ones; all other bits 0.
//   Zero outside INIT and RND.
//  bypass_mix: 1 in every RND beat while last_round.
//   xor_iv_in: 1 in INIT when CBC & encrypt.
//   xor_iv_out: 1 in round-Nr beats when (CBC & decrypt) | CTR.
//  iv_cnt_en: pulses in the first DONE cycle when CTR.
//  Latency (start high in cycle 0): done first high in cycle 1 + BEATS + Nr*(1+BEATS);
//   add 2*Nr for derivation. KEY_DERIVATION alone: done at cycle 1 + 2*Nr.
//  done_ack asserted together with done's first cycle: done is 1 for exactly that one cycle.
//   done_ack outside DONE is ignored.
//  start while busy: ignored, no cfg_err.
//  disable_core: highest priority in any state. Next cycle IDLE, round=0, beat=0; done dropped without ack.
//   disable_core with start in the same cycle: abort wins.
//  Async reset mid-operation: immediate return to reset values.
//  Counter widths: round saturates at Nr and never wraps. RND_W < 4 is a configuration error (elaboration assert).
// STRUCTURE
//  aes_ctrl_pkg: state enum, op/mode/key_size encodings, function nr_of(key_size) -> 10/12/14.
//  Sub-module aes_ctrl_round_cnt: round + beat counters with up/down, clear and saturate.
// TESTING
//  1. 128 ENC ECB, COL_PAR=1, start @0 -> done @55; round 10 at cycle 50; col_en 0001,0010,0100,1000 per round.
//  2. 256 DEC_W_DERIV -> 28 DERIV cycles, round back to 0, beats descending, done @1+4+14*5+28=103.
//  3. 192 CTR with operation_mode=DEC, COL_PAR=2 -> enc_dec=1, done @1+2+12*3=39, iv_cnt_en high @39 only.
//  4. CBC DEC 128 -> xor_iv_out only in round-10 beats; CBC ENC -> xor_iv_in only in cycles 1..4.
//  5. disable_core @20 of run 1 -> IDLE @21, busy=0, round=0; restart completes in 55 cycles.
//  6. key_size=11 start -> cfg_err @1, busy stays 0; done held 5 cycles until done_ack, then IDLE.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared encodings for the AES round sequencer: FSM states, host field codes and
// the round count per key size.
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDeriv,
    StInit,
    StKeyg,
    StRnd,
    StDone
  } state_e;

  localparam logic [1:0] OpEnc       = 2'b00;
  localparam logic [1:0] OpKeyDeriv  = 2'b01;
  localparam logic [1:0] OpDec       = 2'b10;
  localparam logic [1:0] OpDecWDeriv = 2'b11;

  localparam logic [1:0] ModeCbc  = 2'b01;
  localparam logic [1:0] ModeCtr  = 2'b10;
  localparam logic [1:0] ModeRsvd = 2'b11;

  localparam logic [1:0] Key128  = 2'b00;
  localparam logic [1:0] Key192  = 2'b01;
  localparam logic [1:0] Key256  = 2'b10;
  localparam logic [1:0] KeyRsvd = 2'b11;

  function automatic logic [3:0] nr_of(input logic [1:0] key_size);
    case (key_size)
      Key128:  nr_of = 4'd10;
      Key192:  nr_of = 4'd12;
      Key256:  nr_of = 4'd14;
      default: nr_of = 4'd10;
    endcase
  endfunction

endpackage

// File: rtl/aes_ctrl_round_cnt.sv
// Round and beat counters. The round count saturates at nr; the beat counter runs
// up or down and returns to its starting value after the last beat of a phase.
module aes_ctrl_round_cnt #(
  parameter int unsigned RND_W = 4,
  parameter int unsigned BEATS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             round_clr,
  input  logic             round_inc,
  input  logic [RND_W-1:0] nr,
  input  logic             beat_clr,
  input  logic             beat_load,
  input  logic             beat_step,
  input  logic             beat_down,
  output logic [RND_W-1:0] round,
  output logic [1:0]       beat,
  output logic             beat_last
);

  localparam logic [1:0] BeatMax = 2'(BEATS - 1);

  logic [RND_W-1:0] round_q, round_d;
  logic [1:0]       beat_q, beat_d, beat_first;

  assign beat_first = beat_down ? BeatMax : 2'd0;
  assign beat_last  = beat_down ? (beat_q == 2'd0) : (beat_q == BeatMax);
  assign round      = round_q;
  assign beat       = beat_q;

  always_comb begin
    round_d = round_q;
    if (round_clr) begin
      round_d = '0;
    end else if (round_inc && (round_q < nr)) begin
      round_d = round_q + RND_W'(1);
    end
  end

  always_comb begin
    beat_d = beat_q;
    if (beat_clr) begin
      beat_d = 2'd0;
    end else if (beat_load) begin
      beat_d = beat_first;
    end else if (beat_step) begin
      if (beat_last) begin
        beat_d = beat_first;
      end else begin
        beat_d = beat_down ? (beat_q - 2'd1) : (beat_q + 2'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_q <= '0;
      beat_q  <= 2'd0;
    end else begin
      round_q <= round_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// AES-128/192/256 control FSM: sequences key derivation, the initial AddRoundKey,
// and Nr rounds of KEYG + column beats, then holds done until the host acks.
module aes_round_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned COLS    = 4,
  parameter int unsigned COL_PAR = 1,
  parameter int unsigned RND_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             disable_core,
  input  logic [1:0]       operation_mode,
  input  logic [1:0]       aes_mode,
  input  logic [1:0]       key_size,
  input  logic             done_ack,
  output logic             busy,
  output logic             done,
  output logic [RND_W-1:0] round,
  output logic             last_round,
  output logic [1:0]       beat,
  output logic [COLS-1:0]  col_en,
  output logic             sbox_g,
  output logic             key_step,
  output logic             key_dir,
  output logic             bypass_mix,
  output logic             enc_dec,
  output logic             xor_iv_in,
  output logic             xor_iv_out,
  output logic             iv_cnt_en,
  output logic             cfg_err
);

  localparam int unsigned BEATS = COLS / COL_PAR;

  if (RND_W < 4) begin : g_rnd_w_err
    $error("RND_W must be at least 4 to hold round 14");
  end
  if ((COL_PAR != 1 && COL_PAR != 2 && COL_PAR != 4) || BEATS > 4 || BEATS * COL_PAR != COLS)
  begin : g_col_par_err
    $error("COL_PAR must be 1, 2 or 4 and divide COLS into at most 4 beats");
  end

  state_e           state_q, state_d;
  logic [1:0]       op_q, mode_q, ks_q;
  logic             enc_q, ph_q, ph_d, first_q, first_d, cfg_err_q, cfg_err_d;
  logic [RND_W-1:0] nr;
  logic [1:0]       op_eff;
  logic             cfg_bad, deriv_in, enc_in, accept, col_act;
  logic             round_clr, round_inc, beat_clr, beat_load, beat_step, beat_last;

  // CTR always runs the forward cipher, so the requested operation is overridden.
  assign op_eff   = (aes_mode == ModeCtr) ? OpEnc : operation_mode;
  assign deriv_in = (op_eff == OpKeyDeriv) || (op_eff == OpDecWDeriv);
  assign enc_in   = !((op_eff == OpDec) || (op_eff == OpDecWDeriv));
  assign cfg_bad  = (key_size == KeyRsvd) || (aes_mode == ModeRsvd);

  assign nr         = RND_W'(nr_of(ks_q));
  assign last_round = (round == nr);
  assign enc_dec    = enc_q;
  assign cfg_err    = cfg_err_q;

  aes_ctrl_round_cnt #(
    .RND_W(RND_W),
    .BEATS(BEATS)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .round_clr (round_clr),
    .round_inc (round_inc),
    .nr        (nr),
    .beat_clr  (beat_clr),
    .beat_load (beat_load),
    .beat_step (beat_step),
    .beat_down (accept ? !enc_in : !enc_q),
    .round     (round),
    .beat      (beat),
    .beat_last (beat_last)
  );

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    cfg_err_d  = 1'b0;
    round_clr  = 1'b0;
    round_inc  = 1'b0;
    beat_clr   = 1'b0;
    beat_load  = 1'b0;
    beat_step  = 1'b0;
    busy       = (state_q != StIdle);
    done       = 1'b0;
    sbox_g     = 1'b0;
    key_step   = 1'b0;
    key_dir    = 1'b0;
    bypass_mix = 1'b0;
    xor_iv_in  = 1'b0;
    xor_iv_out = 1'b0;
    iv_cnt_en  = 1'b0;
    col_act    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            accept    = 1'b1;
            beat_load = 1'b1;
            if (deriv_in) begin
              state_d   = StDeriv;
              round_inc = 1'b1;
            end else begin
              state_d = StInit;
            end
          end
        end
      end
      StDeriv: begin
        // ph_q = 0: G-function cycle, ph_q = 1: schedule update cycle.
        if (!ph_q) begin
          sbox_g = 1'b1;
        end else begin
          key_step = 1'b1;
          if (last_round) begin
            if (op_q == OpKeyDeriv) begin
              state_d = StDone;
            end else begin
              state_d   = StInit;
              round_clr = 1'b1;
            end
          end else begin
            round_inc = 1'b1;
          end
        end
      end
      StInit: begin
        col_act    = 1'b1;
        bypass_mix = 1'b1;
        xor_iv_in  = (mode_q == ModeCbc) && enc_q;
        beat_step  = 1'b1;
        if (beat_last) begin
          state_d   = StKeyg;
          round_inc = 1'b1;
        end
      end
      StKeyg: begin
        sbox_g   = 1'b1;
        key_step = 1'b1;
        key_dir  = !enc_q;
        state_d  = StRnd;
      end
      StRnd: begin
        col_act    = 1'b1;
        bypass_mix = last_round;
        xor_iv_out = last_round && (((mode_q == ModeCbc) && !enc_q) || (mode_q == ModeCtr));
        beat_step  = 1'b1;
        if (beat_last) begin
          if (last_round) begin
            state_d = StDone;
          end else begin
            state_d   = StKeyg;
            round_inc = 1'b1;
          end
        end
      end
      StDone: begin
        done      = 1'b1;
        iv_cnt_en = first_q && (mode_q == ModeCtr);
        if (done_ack) begin
          state_d   = StIdle;
          round_clr = 1'b1;
          beat_clr  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort outranks every other request, including a same-cycle start.
    if (disable_core) begin
      state_d   = StIdle;
      accept    = 1'b0;
      cfg_err_d = 1'b0;
      round_clr = 1'b1;
      round_inc = 1'b0;
      beat_clr  = 1'b1;
      beat_load = 1'b0;
      beat_step = 1'b0;
    end
  end

  assign ph_d    = (state_q == StDeriv) && (state_d == StDeriv) && !ph_q;
  assign first_d = (state_d == StDone) && (state_q != StDone);

  always_comb begin
    col_en = '0;
    if (col_act) begin
      for (int unsigned i = 0; i < COLS; i++) begin
        col_en[i] = ((i / COL_PAR) == 32'(beat));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= OpEnc;
      mode_q    <= 2'b00;
      ks_q      <= Key128;
      enc_q     <= 1'b0;
      ph_q      <= 1'b0;
      first_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      first_q   <= first_d;
      cfg_err_q <= cfg_err_d;
      if (accept) begin
        op_q   <= op_eff;
        mode_q <= aes_mode;
        ks_q   <= key_size;
        enc_q  <= enc_in;
      end
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: two instances (COL_PAR 1 and 2) share stimulus, a
// cycle-indexed timeline model checks every output, and a queue scores done timing.
module tb_aes_round_sequencer;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [3:0] round;
    logic       last_round;
    logic [1:0] beat;
    logic [3:0] col_en;
    logic       sbox_g;
    logic       key_step;
    logic       key_dir;
    logic       bypass_mix;
    logic       enc_dec;
    logic       xor_iv_in;
    logic       xor_iv_out;
    logic       iv_cnt_en;
    logic       cfg_err;
  } outs_t;

  typedef struct {
    logic [1:0] op;
    logic [1:0] mode;
    logic [1:0] ks;
    int         nr;
    int         lat_a;
    int         lat_b;
    int         ack_dly;
    string      name;
  } vec_t;

  logic       clk, rst_n, start, disable_core, done_ack;
  logic [1:0] operation_mode, aes_mode, key_size;
  outs_t      oa, ob;
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         qa[$];
  int         qb[$];
  logic       pa, pb;

  aes_round_sequencer #(.COLS(4), .COL_PAR(1), .RND_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .disable_core(disable_core),
    .operation_mode(operation_mode), .aes_mode(aes_mode), .key_size(key_size),
    .done_ack(done_ack), .busy(oa.busy), .done(oa.done), .round(oa.round),
    .last_round(oa.last_round), .beat(oa.beat), .col_en(oa.col_en), .sbox_g(oa.sbox_g),
    .key_step(oa.key_step), .key_dir(oa.key_dir), .bypass_mix(oa.bypass_mix),
    .enc_dec(oa.enc_dec), .xor_iv_in(oa.xor_iv_in), .xor_iv_out(oa.xor_iv_out),
    .iv_cnt_en(oa.iv_cnt_en), .cfg_err(oa.cfg_err)
  );

  aes_round_sequencer #(.COLS(4), .COL_PAR(2), .RND_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .disable_core(disable_core),
    .operation_mode(operation_mode), .aes_mode(aes_mode), .key_size(key_size),
    .done_ack(done_ack), .busy(ob.busy), .done(ob.done), .round(ob.round),
    .last_round(ob.last_round), .beat(ob.beat), .col_en(ob.col_en), .sbox_g(ob.sbox_g),
    .key_step(ob.key_step), .key_dir(ob.key_dir), .bypass_mix(ob.bypass_mix),
    .enc_dec(ob.enc_dec), .xor_iv_in(ob.xor_iv_in), .xor_iv_out(ob.xor_iv_out),
    .iv_cnt_en(ob.iv_cnt_en), .cfg_err(ob.cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Expected outputs at cycle t after a start accepted in cycle 0.
  function automatic outs_t model(input vec_t v, input int beats, input int t, input int ack_at,
                                  input int dis_at, output outs_t msk);
    outs_t o;
    bit ctr, cbc, enc, deriv, konly, act;
    int d, lat, u, w, r, p, bi, cp;
    o     = '0;
    msk   = '1;
    ctr   = (v.mode == 2'b10);
    cbc   = (v.mode == 2'b01);
    enc   = ctr || (v.op == 2'b00) || (v.op == 2'b01);
    deriv = !ctr && v.op[0];
    konly = !ctr && (v.op == 2'b01);
    d     = deriv ? 2 * v.nr : 0;
    lat   = konly ? d + 1 : d + beats + v.nr * (beats + 1) + 1;
    o.enc_dec = enc;
    act = 0;
    bi  = 0;
    if (dis_at > 0 && t > dis_at) return o;
    if (t > ack_at) begin
      msk.round      = '0;
      msk.last_round = 1'b0;
      msk.beat       = '0;
      return o;
    end
    o.busy = 1'b1;
    if (t >= lat) begin
      o.done      = 1'b1;
      o.round     = 4'(v.nr);
      o.iv_cnt_en = ctr && (t == lat);
    end else if (t <= d) begin
      o.round    = 4'((t - 1) / 2 + 1);
      o.sbox_g   = ((t - 1) % 2 == 0);
      o.key_step = ((t - 1) % 2 == 1);
    end else begin
      u = t - d;
      if (u <= beats) begin
        act          = 1;
        bi           = enc ? u - 1 : beats - u;
        o.bypass_mix = 1'b1;
        o.xor_iv_in  = cbc && enc;
      end else begin
        w       = u - beats - 1;
        r       = w / (beats + 1) + 1;
        p       = w % (beats + 1);
        o.round = 4'(r);
        if (p == 0) begin
          o.sbox_g   = 1'b1;
          o.key_step = 1'b1;
          o.key_dir  = !enc;
        end else begin
          act          = 1;
          bi           = enc ? p - 1 : beats - p;
          o.bypass_mix = (r == v.nr);
          o.xor_iv_out = (r == v.nr) && ((cbc && !enc) || ctr);
        end
      end
    end
    o.last_round = (int'(o.round) == v.nr);
    if (act) begin
      o.beat = 2'(bi);
      cp = 4 / beats;
      for (int j = 0; j < 4; j++) o.col_en[j] = ((j / cp) == bi);
    end else begin
      msk.beat = '0;
    end
    return o;
  endfunction

  task automatic check(input string nm, input int t, input outs_t act, input outs_t exp,
                       input outs_t msk);
    n_checks++;
    if ((act & msk) !== (exp & msk)) begin
      n_errors++;
      $display("FAIL %s t=%0d got=%h want=%h mask=%h", nm, t, act, exp, msk);
    end
  endtask

  task automatic run(input vec_t v, input int dis_at);
    int    ack_at, last;
    outs_t ea, eb, ma, mb;
    @(negedge clk);
    start          = 1'b1;
    operation_mode = v.op;
    aes_mode       = v.mode;
    key_size       = v.ks;
    if (dis_at == 0) begin
      qa.push_back(cyc + v.lat_a);
      qb.push_back(cyc + v.lat_b);
    end
    ack_at = v.lat_a + v.ack_dly;
    last   = (dis_at > 0) ? dis_at + 1 : ack_at + 1;
    for (int t = 1; t <= last; t++) begin
      @(negedge clk);
      ea = model(v, 4, t, ack_at, dis_at, ma);
      eb = model(v, 2, t, ack_at, dis_at, mb);
      check({v.name, "_a"}, t, oa, ea, ma);
      check({v.name, "_b"}, t, ob, eb, mb);
      start          = (t == 3);
      operation_mode = 2'($urandom_range(0, 3));
      aes_mode       = 2'($urandom_range(0, 3));
      key_size       = (t == 3) ? 2'b11 : 2'($urandom_range(0, 3));
      done_ack       = (t == 2) || (t == ack_at);
      disable_core   = (t == dis_at);
    end
    start        = 1'b0;
    done_ack     = 1'b0;
    disable_core = 1'b0;
  endtask

  task automatic idle_pulse(input string nm, input logic st, input logic dis,
                            input logic [1:0] md, input logic [1:0] ks, input logic exp_err);
    outs_t e, m;
    m = '1;
    e = '0;
    @(negedge clk);
    start          = st;
    disable_core   = dis;
    operation_mode = 2'b00;
    aes_mode       = md;
    key_size       = ks;
    @(negedge clk);
    e.cfg_err = exp_err;
    check({nm, "_a"}, 1, oa, e, m);
    check({nm, "_b"}, 1, ob, e, m);
    start        = 1'b0;
    disable_core = 1'b0;
    @(negedge clk);
    e.cfg_err = 1'b0;
    check({nm, "_a"}, 2, oa, e, m);
    check({nm, "_b"}, 2, ob, e, m);
  endtask

  // Done-timing scoreboard: each accepted run queues its expected done cycle.
  initial begin
    pa = 1'b0;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (oa.done && !pa) begin
        n_checks++;
        if (qa.size() == 0) begin
          n_errors++;
          $display("FAIL sb_done_a unexpected done at cyc=%0d", cyc);
        end else if (qa[0] != cyc) begin
          n_errors++;
          $display("FAIL sb_done_a got cyc=%0d want cyc=%0d", cyc, qa[0]);
          void'(qa.pop_front());
        end else begin
          void'(qa.pop_front());
        end
      end
      if (ob.done && !pb) begin
        n_checks++;
        if (qb.size() == 0) begin
          n_errors++;
          $display("FAIL sb_done_b unexpected done at cyc=%0d", cyc);
        end else if (qb[0] != cyc) begin
          n_errors++;
          $display("FAIL sb_done_b got cyc=%0d want cyc=%0d", cyc, qb[0]);
          void'(qb.pop_front());
        end else begin
          void'(qb.pop_front());
        end
      end
      pa = oa.done;
      pb = ob.done;
    end
  end

  initial begin
    vec_t  vecs[9];
    outs_t z, m;
    vecs[0] = '{2'b00, 2'b00, 2'b00, 10,  55, 33, 0, "enc_ecb_128"};
    vecs[1] = '{2'b11, 2'b00, 2'b10, 14, 103, 73, 1, "decwd_ecb_256"};
    vecs[2] = '{2'b10, 2'b10, 2'b01, 12,  65, 39, 0, "dec_ctr_192"};
    vecs[3] = '{2'b10, 2'b01, 2'b00, 10,  55, 33, 4, "dec_cbc_128"};
    vecs[4] = '{2'b00, 2'b01, 2'b00, 10,  55, 33, 0, "enc_cbc_128"};
    vecs[5] = '{2'b01, 2'b00, 2'b01, 12,  25, 25, 2, "keyder_192"};
    vecs[6] = '{2'b00, 2'b10, 2'b10, 14,  75, 45, 0, "enc_ctr_256"};
    vecs[7] = '{2'b11, 2'b01, 2'b00, 10,  75, 53, 0, "decwd_cbc_128"};
    vecs[8] = '{2'b01, 2'b10, 2'b00, 10,  55, 33, 0, "keyder_ctr_128"};
    z = '0;
    m = '1;

    rst_n          = 1'b0;
    start          = 1'b0;
    disable_core   = 1'b0;
    done_ack       = 1'b0;
    operation_mode = 2'b00;
    aes_mode       = 2'b00;
    key_size       = 2'b00;
    repeat (2) @(negedge clk);
    check("reset_a", 0, oa, z, m);
    check("reset_b", 0, ob, z, m);
    rst_n = 1'b1;

    idle_pulse("rej_key", 1'b1, 1'b0, 2'b00, 2'b11, 1'b1);
    idle_pulse("rej_mode", 1'b1, 1'b0, 2'b11, 2'b00, 1'b1);
    idle_pulse("abort_start", 1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
    idle_pulse("abort_bad", 1'b1, 1'b1, 2'b00, 2'b11, 1'b0);

    for (int i = 0; i < 9; i++) run(vecs[i], 0);

    run(vecs[0], 20);
    run(vecs[0], 0);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    start          = 1'b1;
    operation_mode = 2'b00;
    aes_mode       = 2'b01;
    key_size       = 2'b00;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_a", 10, oa, z, m);
    check("async_rst_b", 10, ob, z, m);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_a", 12, oa, z, m);
    check("post_rst_b", 12, ob, z, m);

    n_checks++;
    if (qa.size() != 0) begin
      n_errors++;
      $display("FAIL sb_pending_a got %0d outstanding want 0", qa.size());
    end
    n_checks++;
    if (qb.size() != 0) begin
      n_errors++;
      $display("FAIL sb_pending_b got %0d outstanding want 0", qb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
